// File: rtl/riscv_prefetch_ctrl_if.sv
// Memory request port and fetch-FIFO push port of the prefetch controller.
// master = controller side, slave = memory/FIFO side.
interface riscv_prefetch_ctrl_if;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        fifo_valid_o;
  logic [31:0] fifo_addr_o;
  logic [31:0] fifo_rdata_o;
  logic        fifo_ready_i;
  logic        fifo_clear_o;

  modport master (
    output instr_req_o, instr_addr_o,
    input  instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    output fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    input  fifo_ready_i
  );

  modport slave (
    input  instr_req_o, instr_addr_o,
    output instr_gnt_i, instr_rvalid_i, instr_rdata_i,
    input  fifo_valid_o, fifo_addr_o, fifo_rdata_o, fifo_clear_o,
    output fifo_ready_i
  );
endinterface

// File: rtl/riscv_prefetch_ctrl.sv
// Instruction-fetch request controller: one outstanding word fetch at a time,
// pushes returned words with their address into the fetch FIFO, flushes on branch.
module riscv_prefetch_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] boot_addr_i,
  input  logic        req_i,
  input  logic        branch_i,
  input  logic [31:0] branch_addr_i,
  output logic        busy_o,
  riscv_prefetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID,
    WAIT_ABORTED
  } state_t;

  state_t      state, state_n;
  logic [31:0] fetch_addr, fetch_n;
  logic [31:0] resp_addr, resp_n;
  logic        gnt_aborted, aborted_n;
  logic        issue;
  logic        launch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      fetch_addr  <= boot_addr_i & 32'hFFFF_FFFE;
      resp_addr   <= '0;
      gnt_aborted <= 1'b0;
    end else begin
      state       <= state_n;
      fetch_addr  <= fetch_n;
      resp_addr   <= resp_n;
      gnt_aborted <= aborted_n;
    end
  end

  // resp_addr is captured at launch rather than at grant, so while waiting for
  // gnt it holds the pending request address even if a branch overwrites fetch_addr.
  always_comb begin
    issue     = req_i & bus.fifo_ready_i & ~branch_i;
    launch    = 1'b0;
    state_n   = state;
    fetch_n   = fetch_addr;
    resp_n    = resp_addr;
    aborted_n = gnt_aborted;

    bus.instr_req_o  = 1'b0;
    bus.instr_addr_o = {fetch_addr[31:2], 2'b00};
    bus.fifo_valid_o = 1'b0;
    bus.fifo_addr_o  = resp_addr;
    bus.fifo_rdata_o = bus.instr_rdata_i;
    bus.fifo_clear_o = branch_i;

    case (state)
      IDLE: begin
        launch = issue;
      end
      WAIT_GNT: begin
        bus.instr_req_o  = 1'b1;
        bus.instr_addr_o = {resp_addr[31:2], 2'b00};
        aborted_n        = gnt_aborted | branch_i;
        if (bus.instr_gnt_i) begin
          if (gnt_aborted || branch_i) begin
            state_n = WAIT_ABORTED;
          end else begin
            state_n = WAIT_RVALID;
            fetch_n = {resp_addr[31:2], 2'b00} + 32'd4;
          end
        end
      end
      WAIT_RVALID: begin
        if (bus.instr_rvalid_i) begin
          state_n = IDLE;
          if (!branch_i) begin
            bus.fifo_valid_o = 1'b1;
            launch           = issue;
          end
        end else if (branch_i) begin
          state_n = WAIT_ABORTED;
        end
      end
      WAIT_ABORTED: begin
        if (bus.instr_rvalid_i) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    if (launch) begin
      bus.instr_req_o  = 1'b1;
      bus.instr_addr_o = {fetch_addr[31:2], 2'b00};
      resp_n           = fetch_addr;
      aborted_n        = 1'b0;
      if (bus.instr_gnt_i) begin
        state_n = WAIT_RVALID;
        fetch_n = {fetch_addr[31:2], 2'b00} + 32'd4;
      end else begin
        state_n = WAIT_GNT;
      end
    end

    if (branch_i) fetch_n = branch_addr_i & 32'hFFFF_FFFE;

    busy_o = (state != IDLE);
  end

endmodule

// File: tb/tb_riscv_prefetch_ctrl.sv
// Bench for riscv_prefetch_ctrl: directed scenarios with literal expectations plus
// a randomized run checked every cycle against a transaction-level model.
module tb_riscv_prefetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] boot_addr;
  logic        req;
  logic        branch;
  logic [31:0] branch_addr;
  logic        busy;

  riscv_prefetch_ctrl_if bus ();

  riscv_prefetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .boot_addr_i   (boot_addr),
    .req_i         (req),
    .branch_i      (branch),
    .branch_addr_i (branch_addr),
    .busy_o        (busy),
    .bus           (bus.master)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // memory behaviour: 0 = always grant, 1 = random grant, 2 = never grant
  int          gnt_mode;
  int          lat_cfg;   // 0 = random latency 1..3
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_addr;

  // snapshot of DUT outputs at the last negedge
  logic        s_req, s_valid, s_clear, s_busy;
  logic [31:0] s_addr, s_faddr;

  // transaction-level reference: fetch pointer plus at most one outstanding request
  logic [31:0] m_fetch;
  logic        o_valid, o_gnt, o_drop;
  logic [31:0] o_addr;

  function automatic logic [31:0] align4(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return align4(a) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    logic        issue, launch;
    logic        e_req, e_valid;
    logic [31:0] e_addr, e_faddr;
    issue   = req & bus.fifo_ready_i & ~branch;
    launch  = 1'b0;
    e_req   = 1'b0;
    e_valid = 1'b0;
    e_addr  = align4(m_fetch);
    e_faddr = '0;

    chk("busy", 32'(busy), 32'(o_valid));

    if (!o_valid) begin
      launch = issue;
    end else if (!o_gnt) begin
      e_req  = 1'b1;
      e_addr = align4(o_addr);
      if (branch) o_drop = 1'b1;
      if (bus.instr_gnt_i) begin
        o_gnt = 1'b1;
        if (!o_drop) m_fetch = align4(o_addr) + 32'd4;
      end
    end else if (bus.instr_rvalid_i) begin
      if (!o_drop && !branch) begin
        e_valid = 1'b1;
        e_faddr = o_addr;
        launch  = issue;
      end
      o_valid = 1'b0;
    end else if (branch) begin
      o_drop = 1'b1;
    end

    if (launch) begin
      e_req   = 1'b1;
      e_addr  = align4(m_fetch);
      o_valid = 1'b1;
      o_addr  = m_fetch;
      o_drop  = 1'b0;
      o_gnt   = bus.instr_gnt_i;
      if (bus.instr_gnt_i) m_fetch = align4(m_fetch) + 32'd4;
    end
    if (branch) m_fetch = branch_addr & 32'hFFFF_FFFE;

    chk("instr_req", 32'(bus.instr_req_o), 32'(e_req));
    if (e_req) chk("instr_addr", bus.instr_addr_o, e_addr);
    chk("fifo_clear", 32'(bus.fifo_clear_o), 32'(branch));
    chk("fifo_valid", 32'(bus.fifo_valid_o), 32'(e_valid));
    if (e_valid) begin
      chk("fifo_addr", bus.fifo_addr_o, e_faddr);
      chk("fifo_rdata", bus.fifo_rdata_o, mem_word(e_faddr));
    end
  endtask

  task automatic tick();
    logic        fire, rv;
    logic [31:0] fire_addr;
    bus.instr_rvalid_i = mem_pend && (mem_cnt == 0);
    bus.instr_rdata_i  = bus.instr_rvalid_i ? mem_word(mem_addr) : $urandom;
    case (gnt_mode)
      0:       bus.instr_gnt_i = 1'b1;
      1:       bus.instr_gnt_i = 1'($urandom_range(0, 1));
      default: bus.instr_gnt_i = 1'b0;
    endcase

    @(negedge clk);
    s_req     = bus.instr_req_o;
    s_addr    = bus.instr_addr_o;
    s_valid   = bus.fifo_valid_o;
    s_faddr   = bus.fifo_addr_o;
    s_clear   = bus.fifo_clear_o;
    s_busy    = busy;
    fire      = bus.instr_req_o & bus.instr_gnt_i;
    fire_addr = bus.instr_addr_o;
    rv        = bus.instr_rvalid_i;
    if (rst) begin
      m_fetch = boot_addr & 32'hFFFF_FFFE;
      o_valid = 1'b0;
      o_gnt   = 1'b0;
      o_drop  = 1'b0;
      o_addr  = '0;
    end else begin
      model_step();
    end

    @(posedge clk);
    if (rst) begin
      mem_pend = 1'b0;
    end else begin
      if (rv) mem_pend = 1'b0;
      else if (mem_pend && mem_cnt > 0) mem_cnt--;
      if (fire) begin
        mem_pend = 1'b1;
        mem_cnt  = (lat_cfg == 0) ? int'($urandom_range(0, 2)) : lat_cfg - 1;
        mem_addr = fire_addr;
      end
    end
    #1;
  endtask

  task automatic step(input logic r, input logic rdy, input logic b, input logic [31:0] ba);
    req              = r;
    bus.fifo_ready_i = rdy;
    branch           = b;
    branch_addr      = ba;
    tick();
  endtask

  initial begin
    logic [31:0] tmp;
    int unsigned r;
    rst = 1'b1; boot_addr = 32'h80; req = 1'b0; branch = 1'b0; branch_addr = '0;
    bus.fifo_ready_i = 1'b1; bus.instr_gnt_i = 1'b0;
    bus.instr_rvalid_i = 1'b0; bus.instr_rdata_i = '0;
    gnt_mode = 0; lat_cfg = 1; mem_pend = 1'b0; mem_cnt = 0; mem_addr = '0;
    m_fetch = '0; o_valid = 1'b0; o_gnt = 1'b0; o_drop = 1'b0; o_addr = '0;

    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    rst = 1'b0;

    // boot sequence
    step(0, 1, 0, 0);
    chk("rst_req", 32'(s_req), 0);   chk("rst_addr", s_addr, 32'h80);
    chk("rst_busy", 32'(s_busy), 0); chk("rst_valid", 32'(s_valid), 0);
    chk("rst_clear", 32'(s_clear), 0);
    step(1, 1, 0, 0); chk("boot_req0", 32'(s_req), 1); chk("boot_addr0", s_addr, 32'h80);
    step(1, 1, 0, 0); chk("boot_addr1", s_addr, 32'h84);
    chk("boot_push0", 32'(s_valid), 1); chk("boot_faddr0", s_faddr, 32'h80);
    step(1, 1, 0, 0); chk("boot_addr2", s_addr, 32'h88); chk("boot_faddr1", s_faddr, 32'h84);
    chk("boot_busy", 32'(s_busy), 1);
    step(0, 1, 0, 0); chk("boot_faddr2", s_faddr, 32'h88); chk("boot_stop", 32'(s_req), 0);

    // grant stall with req/ready toggling
    gnt_mode = 2;
    step(1, 1, 0, 0); chk("stall_req", 32'(s_req), 1); chk("stall_addr", s_addr, 32'h8C);
    for (int i = 0; i < 3; i++) begin
      step(1'(i % 2), 1'((i + 1) % 2), 0, 0);
      chk("stall_hold_req", 32'(s_req), 1); chk("stall_hold_addr", s_addr, 32'h8C);
      chk("stall_no_push", 32'(s_valid), 0);
    end
    gnt_mode = 0;
    step(0, 1, 0, 0); chk("stall_gnt_addr", s_addr, 32'h8C); chk("stall_gnt_push", 32'(s_valid), 0);
    step(0, 1, 0, 0); chk("stall_push", 32'(s_valid), 1); chk("stall_faddr", s_faddr, 32'h8C);
    step(0, 1, 0, 0); chk("stall_one_push", 32'(s_valid), 0); chk("stall_idle", 32'(s_busy), 0);

    // branch while awaiting rvalid
    step(0, 1, 1, 32'h100); chk("br0_clear", 32'(s_clear), 1);
    lat_cfg = 3;
    step(1, 1, 0, 0); chk("br1_addr", s_addr, 32'h100);
    step(0, 1, 1, 32'h206); chk("br1_clear", 32'(s_clear), 1); chk("br1_nopush", 32'(s_valid), 0);
    step(1, 1, 0, 0); chk("br1_abort_req", 32'(s_req), 0); chk("br1_abort_busy", 32'(s_busy), 1);
    step(1, 1, 0, 0); chk("br1_swallow", 32'(s_valid), 0); chk("br1_swallow_req", 32'(s_req), 0);
    lat_cfg = 1;
    step(1, 1, 0, 0); chk("br1_new_addr", s_addr, 32'h204);
    step(1, 1, 0, 0); chk("br1_faddr", s_faddr, 32'h206); chk("br1_next_addr", s_addr, 32'h208);
    step(0, 1, 0, 0); chk("br1_faddr2", s_faddr, 32'h208); chk("br1_valid2", 32'(s_valid), 1);

    // branch coinciding with rvalid
    step(1, 1, 0, 0); chk("br2_addr", s_addr, 32'h20C);
    step(0, 1, 1, 32'h300); chk("br2_drop", 32'(s_valid), 0); chk("br2_clear", 32'(s_clear), 1);
    step(1, 1, 0, 0); chk("br2_idle", 32'(s_busy), 0); chk("br2_req", 32'(s_req), 1);
    chk("br2_new_addr", s_addr, 32'h300);
    step(0, 1, 0, 0); chk("br2_faddr", s_faddr, 32'h300);

    // back-pressure
    step(1, 0, 0, 0); chk("bp_idle_noreq", 32'(s_req), 0);
    step(1, 1, 0, 0); chk("bp_addr", s_addr, 32'h304);
    step(1, 0, 0, 0); chk("bp_push", 32'(s_valid), 1); chk("bp_faddr", s_faddr, 32'h304);
    chk("bp_noreq", 32'(s_req), 0);
    step(1, 0, 0, 0); chk("bp_settled", 32'(s_busy), 0);

    // address wrap, then reset while awaiting grant
    rst = 1'b1; boot_addr = 32'hFFFF_FFFC;
    step(0, 1, 0, 0);
    rst = 1'b0;
    step(1, 1, 0, 0); chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
    step(1, 1, 0, 0); chk("wrap_addr1", s_addr, 32'h0); chk("wrap_faddr", s_faddr, 32'hFFFF_FFFC);
    gnt_mode = 2;
    step(1, 1, 0, 0); chk("wrap_addr2", s_addr, 32'h4); chk("wrap_faddr1", s_faddr, 32'h0);
    rst = 1'b1;
    step(1, 1, 0, 0);
    rst = 1'b0;
    step(0, 1, 0, 0); chk("rst_mid_req", 32'(s_req), 0); chk("rst_mid_busy", 32'(s_busy), 0);

    // randomized traffic
    gnt_mode = 1; lat_cfg = 0;
    repeat (4000) begin
      r   = $urandom_range(0, 499);
      tmp = $urandom;
      if (r < 10) tmp = 32'hFFFF_FFF8 | (tmp & 32'h7);
      rst = (r == 0);
      step($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0,
           $urandom_range(0, 9) == 0, tmp);
      rst = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
